// File: rtl/timer_arbiter.sv
// Round-robin arbiter that lends one shared cycle timer to N_REQ requesters,
// latching the winner's count and pulsing ack when the timer reports done.
module timer_arbiter #(
  parameter int N_REQ = 4,
  parameter int CW    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*CW-1:0] req_count,
  output logic [N_REQ-1:0]    grant,
  output logic [N_REQ-1:0]    ack,
  output logic                busy,
  output logic                timer_start,
  output logic [CW-1:0]       timer_count,
  input  logic                timer_done
);

  localparam int PW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] owner;
  logic [PW-1:0] sel;
  logic [PW-1:0] sel_next;
  logic          found;
  logic [CW-1:0] counts [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      counts[i] = req_count[i*CW +: CW];
    end
  end

  // First pending request at or above rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    logic [PW:0] idx;
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(N_REQ)) begin
        idx = idx - (PW+1)'(N_REQ);
      end
      if (!found && req[idx[PW-1:0]]) begin
        found = 1'b1;
        sel   = idx[PW-1:0];
      end
    end
  end

  assign sel_next = (sel == PW'(N_REQ - 1)) ? '0 : sel + PW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      ack         <= '0;
      busy        <= 1'b0;
      timer_start <= 1'b0;
      timer_count <= '0;
      rr_ptr      <= '0;
      owner       <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            state       <= RUN;
            busy        <= 1'b1;
            grant       <= N_REQ'(1) << sel;
            owner       <= sel;
            timer_start <= 1'b1;
            timer_count <= counts[sel];
            rr_ptr      <= sel_next;
          end
        end
        // Completion takes priority over a same-cycle withdrawal.
        RUN: begin
          if (timer_done) begin
            state       <= DRAIN;
            timer_start <= 1'b0;
            ack         <= grant;
          end else if (!req[owner]) begin
            state       <= DRAIN;
            timer_start <= 1'b0;
          end
        end
        DRAIN: begin
          if (!timer_done) begin
            state <= IDLE;
            grant <= '0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          grant       <= '0;
          busy        <= 1'b0;
          timer_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter: shared-timer model, per-cycle reference model and
// directed scenarios with hand-computed timings.
module tb_timer_arbiter;

  localparam int N  = 4;
  localparam int CW = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req;
  logic [N*CW-1:0]   req_count;
  logic [N-1:0]      grant;
  logic [N-1:0]      ack;
  logic              busy;
  logic              timer_start;
  logic [CW-1:0]     timer_count;
  logic              timer_done;

  int checks = 0;
  int passes = 0;
  bit model_on = 1'b0;

  timer_arbiter #(.N_REQ(N), .CW(CW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_count(req_count),
    .grant(grant), .ack(ack), .busy(busy), .timer_start(timer_start),
    .timer_count(timer_count), .timer_done(timer_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Shared timer: done rises count+2 cycles after start rises, clears 1 cycle after start falls.
  int unsigned tcnt;
  always @(posedge clk) begin
    if (timer_start !== 1'b1) begin
      tcnt       <= 0;
      timer_done <= 1'b0;
    end else begin
      tcnt <= tcnt + 1;
      if (tcnt + 1 >= timer_count + 2) timer_done <= 1'b1;
    end
  end

  // Reference model: owner index (-1 = free), running flag, latched count, next search start.
  int           m_owner = -1;
  int           m_ptr   = 0;
  int           m_ack   = -1;
  bit           m_run   = 1'b0;
  logic [CW-1:0] m_cnt  = '0;

  always @(posedge clk) begin
    m_ack = -1;
    if (reset) begin
      m_owner = -1;
      m_ptr   = 0;
      m_run   = 1'b0;
      m_cnt   = '0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++)
        if (m_owner < 0 && req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
      if (m_owner >= 0) begin
        m_run = 1'b1;
        m_cnt = req_count[m_owner*CW +: CW];
        m_ptr = (m_owner + 1) % N;
      end
    end else if (m_run) begin
      if (timer_done) begin
        m_run = 1'b0;
        m_ack = m_owner;
      end else if (!req[m_owner]) begin
        m_run = 1'b0;
      end
    end else if (!timer_done) begin
      m_owner = -1;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      checkOutput("grant", grant, (m_owner >= 0) ? (64'd1 << m_owner) : 64'd0);
      checkOutput("ack", ack, (m_ack >= 0) ? (64'd1 << m_ack) : 64'd0);
      checkOutput("busy", busy, m_owner >= 0);
      checkOutput("timer_start", timer_start, m_run);
      checkOutput("timer_count", timer_count, m_cnt);
      checkOutput("grant_onehot", $countones(grant) <= 1, 1);
    end
  end

  task automatic applyStimulus(input logic [N-1:0] r, input logic [CW-1:0] c0, c1, c2, c3);
    req       = r;
    req_count = {c3, c2, c1, c0};
  endtask

  function automatic bit cond(input int kind);
    case (kind)
      0:       return grant != '0;
      1:       return ack != '0;
      default: return busy == 1'b0;
    endcase
  endfunction

  // Waits (bounded) at negedges for a condition; n = negedges waited.
  task automatic waitUntil(input int kind, input string name, input int limit, output int n);
    n = 0;
    while (!cond(kind) && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_reached"}, cond(kind), 1);
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int n;
    int exp_order [5];
    int fair_order [3];
    logic [N-1:0] cur;

    reset = 1'b1;
    applyStimulus('0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    checkOutput("reset_grant", grant, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_start", timer_start, 0);
    checkOutput("reset_count", timer_count, 0);
    reset = 1'b0;
    model_on = 1'b1;

    // Single request, count 5: grant next edge, ack 8 edges after grant.
    applyStimulus(4'b0001, 5, 0, 0, 0);
    @(negedge clk);
    checkOutput("t1_grant", grant, 4'b0001);
    checkOutput("t1_start", timer_start, 1);
    checkOutput("t1_count", timer_count, 5);
    waitUntil(1, "t1_ack", 30, n);
    checkOutput("t1_ack_latency", n, 8);
    checkOutput("t1_ack_value", ack, 4'b0001);
    req = '0;
    @(negedge clk);
    checkOutput("t1_ack_pulse", ack, 0);
    checkOutput("t1_drain_busy", busy, 1);
    @(negedge clk);
    checkOutput("t1_idle_busy", busy, 0);

    // Contention from a fresh reset: 0,1,2,3,0.
    doReset();
    exp_order = '{0, 1, 2, 3, 0};
    applyStimulus(4'b1111, 3, 4, 5, 6);
    for (int g = 0; g < 5; g++) begin
      waitUntil(0, "t2_grant", 20, n);
      checkOutput("t2_order", grant, 4'b0001 << exp_order[g]);
      waitUntil(1, "t2_ack", 30, n);
      checkOutput("t2_ack_idx", ack, 4'b0001 << exp_order[g]);
      if (g == 4) req = '0;
      waitUntil(2, "t2_release", 10, n);
    end

    // Serve requester 1 so the pointer sits at 2, then 0,1,2 pending -> 2,0,1.
    applyStimulus(4'b0010, 0, 2, 0, 0);
    waitUntil(0, "t3_pre_grant", 20, n);
    checkOutput("t3_pre_idx", grant, 4'b0010);
    waitUntil(1, "t3_pre_ack", 30, n);
    req = '0;
    waitUntil(2, "t3_pre_release", 10, n);
    fair_order = '{2, 0, 1};
    cur = 4'b0111;
    applyStimulus(cur, 1, 1, 1, 0);
    for (int g = 0; g < 3; g++) begin
      waitUntil(0, "t3_grant", 20, n);
      checkOutput("t3_order", grant, 4'b0001 << fair_order[g]);
      waitUntil(1, "t3_ack", 30, n);
      cur = cur & ~ack;
      req = cur;
      waitUntil(2, "t3_release", 10, n);
    end

    // Withdraw requester 1 ten cycles into a long count.
    applyStimulus(4'b0010, 0, 100, 0, 0);
    waitUntil(0, "t4_grant", 20, n);
    repeat (10) @(negedge clk);
    req = '0;
    @(negedge clk);
    checkOutput("t4_start_drop", timer_start, 0);
    checkOutput("t4_no_ack", ack, 0);
    @(negedge clk);
    checkOutput("t4_idle", busy, 0);

    // Reset at RUN cycle 7, then a normal grant for requester 2.
    applyStimulus(4'b0001, 50, 0, 0, 0);
    waitUntil(0, "t5_grant", 20, n);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    req = '0;
    @(negedge clk);
    checkOutput("t5_rst_grant", grant, 0);
    checkOutput("t5_rst_ack", ack, 0);
    checkOutput("t5_rst_busy", busy, 0);
    checkOutput("t5_rst_start", timer_start, 0);
    checkOutput("t5_rst_count", timer_count, 0);
    reset = 1'b0;
    applyStimulus(4'b0100, 0, 0, 2, 0);
    @(negedge clk);
    checkOutput("t5_grant2", grant, 4'b0100);
    checkOutput("t5_count2", timer_count, 2);
    waitUntil(1, "t5_ack", 30, n);
    checkOutput("t5_ack_latency", n, 5);
    req = '0;
    waitUntil(2, "t5_release", 10, n);

    // Count changed one cycle after grant must not affect the running operation.
    applyStimulus(4'b0001, 5, 0, 0, 0);
    waitUntil(0, "t6_grant", 20, n);
    @(negedge clk);
    req_count[CW-1:0] = 50;
    checkOutput("t6_count_held", timer_count, 5);
    waitUntil(1, "t6_ack", 60, n);
    checkOutput("t6_ack_latency", n + 1, 8);
    checkOutput("t6_count_after", timer_count, 5);
    req = '0;
    waitUntil(2, "t6_release", 10, n);

    // Zero count is passed straight through: ack 3 edges after grant.
    applyStimulus(4'b1000, 0, 0, 0, 0);
    waitUntil(0, "t7_grant", 20, n);
    checkOutput("t7_count", timer_count, 0);
    waitUntil(1, "t7_ack", 20, n);
    checkOutput("t7_ack_latency", n, 3);
    checkOutput("t7_ack_idx", ack, 4'b1000);
    req = '0;
    waitUntil(2, "t7_release", 10, n);

    @(negedge clk);
    model_on = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
